apb_timer: RTL

- 32-bit programmable APB timer with an 8-bit data bus. It generates the `timer_int` level source that feeds bit 0 of the interrupt controller.
- Provides a prescaler, a compare-match periodic or one-shot mode, a sticky match/overflow status, and an interrupt enable.
- Sits on the same 8-bit APB segment as the interrupt controller. Its `timer_int` is consumed as a level, active-high interrupt (polarity 1, edge 0).

---
 rtl/apb_timer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/apb_timer.sv
// 32-bit APB timer, 8-bit data bus: prescaler, compare match (periodic/one-shot), sticky MATCH/OVF, level IRQ.
// Optional coherent CNT read shadow enabled by defining TIMER_SNAPSHOT_EN.
module apb_timer #(
  parameter logic [19:0] BASE_ADDR = 20'h00000,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic        apb_pclk,
  input  logic        apb_prstn,
  input  logic        apb_psel,
  input  logic [19:0] apb_paddr,
  input  logic        apb_pwrite,
  input  logic        apb_penable,
  input  logic [7:0]  apb_pwdata,
  output logic [7:0]  apb_prdata,
  output logic        timer_int
);

  logic               we;
  logic [19:0]        off;
  logic               tick;
  logic               clr;
  logic               cnt_wr;
  logic               set_match;
  logic               set_ovf;
  logic [1:0]         stat_w1c;

  logic               en_q, en_d;
  logic               oneshot_q, oneshot_d;
  logic               ie_q, ie_d;
  logic               match_q, match_d;
  logic               ovf_q, ovf_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        cmp_q, cmp_d;
  logic [31:0]        cnt_q, cnt_d;

  assign we        = apb_psel & apb_penable & apb_pwrite;
  assign off       = apb_paddr - BASE_ADDR;
  assign tick      = en_q & (pcnt_q == presc_q);
  assign timer_int = ie_q & match_q;

  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    ie_d      = ie_q;
    presc_d   = presc_q;
    cmp_d     = cmp_q;
    cnt_d     = cnt_q;
    clr       = 1'b0;
    cnt_wr    = 1'b0;
    stat_w1c  = '0;
    set_match = 1'b0;
    set_ovf   = 1'b0;

    if (we) begin
      case (off)
        20'h0: begin
          en_d      = apb_pwdata[0];
          oneshot_d = apb_pwdata[1];
          ie_d      = apb_pwdata[2];
          clr       = apb_pwdata[3];
        end
        20'h1: stat_w1c = apb_pwdata[1:0];
        20'h2: presc_d = PRESC_W'(apb_pwdata);
        20'h4: cmp_d[7:0]   = apb_pwdata;
        20'h5: cmp_d[15:8]  = apb_pwdata;
        20'h6: cmp_d[23:16] = apb_pwdata;
        20'h7: cmp_d[31:24] = apb_pwdata;
        20'h8: begin cnt_d[7:0]   = apb_pwdata; cnt_wr = 1'b1; end
        20'h9: begin cnt_d[15:8]  = apb_pwdata; cnt_wr = 1'b1; end
        20'hA: begin cnt_d[23:16] = apb_pwdata; cnt_wr = 1'b1; end
        20'hB: begin cnt_d[31:24] = apb_pwdata; cnt_wr = 1'b1; end
        default: ;
      endcase
    end

    pcnt_d = (en_q && !tick) ? pcnt_q + 1'b1 : '0;

    // CLR and CPU CNT writes both swallow a coincident tick
    if (clr) begin
      cnt_d  = '0;
      pcnt_d = '0;
    end else if (!cnt_wr && tick) begin
      if (cnt_q == cmp_q) begin
        cnt_d     = '0;
        set_match = 1'b1;
        if (oneshot_q) en_d = 1'b0;
      end else if (cnt_q == '1) begin
        cnt_d   = '0;
        set_ovf = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    match_d = set_match | (match_q & ~stat_w1c[0]);
    ovf_d   = set_ovf   | (ovf_q   & ~stat_w1c[1]);
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      ie_q      <= 1'b0;
      match_q   <= 1'b0;
      ovf_q     <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      cmp_q     <= '1;
      cnt_q     <= '0;
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      ie_q      <= ie_d;
      match_q   <= match_d;
      ovf_q     <= ovf_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      cmp_q     <= cmp_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  logic        re;
  logic [23:0] shadow_q, shadow_d;

  assign re = apb_psel & apb_penable & ~apb_pwrite;

  // reading byte 0 freezes the upper bytes so later byte reads are coherent
  always_comb shadow_d = (re && off == 20'h8) ? cnt_q[31:8] : shadow_q;

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) shadow_q <= '0;
    else            shadow_q <= shadow_d;
  end
`endif

  always_comb begin
    apb_prdata = '0;
    case (off)
      20'h0: apb_prdata = {5'b0, ie_q, oneshot_q, en_q};
      20'h1: apb_prdata = {6'b0, ovf_q, match_q};
      20'h2: apb_prdata = 8'(presc_q);
      20'h4: apb_prdata = cmp_q[7:0];
      20'h5: apb_prdata = cmp_q[15:8];
      20'h6: apb_prdata = cmp_q[23:16];
      20'h7: apb_prdata = cmp_q[31:24];
      20'h8: apb_prdata = cnt_q[7:0];
`ifdef TIMER_SNAPSHOT_EN
      20'h9: apb_prdata = shadow_q[7:0];
      20'hA: apb_prdata = shadow_q[15:8];
      20'hB: apb_prdata = shadow_q[23:16];
`else
      20'h9: apb_prdata = cnt_q[15:8];
      20'hA: apb_prdata = cnt_q[23:16];
      20'hB: apb_prdata = cnt_q[31:24];
`endif
      default: apb_prdata = '0;
    endcase
  end

endmodule
